// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, 2-flop synchronised input.
// Latency: 3 + HALF_BIT + 10*CLKS_PER_BIT + 1 clk from the rx falling edge to data_valid/frame_err.
// Backpressure: none; data_valid and frame_err are single-cycle strobes the consumer must take.
module uart_rx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2,
    parameter int LED_HOLD     = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy,
    output logic       led
);

    localparam int               LED_W     = $clog2(LED_HOLD + 1);
    localparam logic [13:0]      BIT_LAST  = 14'(CLKS_PER_BIT - 1);
    localparam logic [13:0]      HALF_LAST = 14'(HALF_BIT - 1);
    localparam logic [LED_W-1:0] LED_LOAD  = LED_W'(LED_HOLD);
    localparam logic [LED_W-1:0] LED_ONE   = LED_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Input conditioning: rx_meta_q/rx_s_q form the synchroniser, rx_prev_q is rx_s delayed by one.
    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q, rx_s_d;
    logic             rx_prev_q, rx_prev_d;

    // Frame datapath.
    state_t           state_q, state_d;
    logic [13:0]      clk_count_q, clk_count_d;
    logic [2:0]       bit_index_q, bit_index_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_bit_q, parity_bit_d;
    logic             stop_bit_q, stop_bit_d;
    logic             done_q, done_d;

    // Registered outputs.
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_busy_q, rx_busy_d;
    logic [LED_W-1:0] led_cnt_q, led_cnt_d;

    // Next-state logic for the synchroniser, the frame FSM, the result stage and the LED stretcher.
    always_comb begin
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;
        rx_prev_d    = rx_s_q;

        state_d      = state_q;
        clk_count_d  = clk_count_q;
        bit_index_d  = bit_index_q;
        shift_d      = shift_q;
        parity_bit_d = parity_bit_q;
        stop_bit_d   = stop_bit_q;
        done_d       = 1'b0;

        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = 1'b0;
        led_cnt_d    = (led_cnt_q != '0) ? (led_cnt_q - LED_ONE) : led_cnt_q;

        // Result stage runs one cycle after the stop sample so outputs come from flops only.
        if (done_q) begin
            if (stop_bit_q) begin
                data_out_d   = shift_q;
                data_valid_d = 1'b1;
                parity_err_d = (^shift_q) ^ parity_bit_q;
                led_cnt_d    = LED_LOAD;
            end else begin
                frame_err_d  = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                // Falling edge only; a line stuck low never looks like a new start.
                if (rx_prev_q && !rx_s_q) begin
                    state_d     = S_START;
                    clk_count_d = '0;
                end
            end
            S_START: begin
                if (clk_count_q == HALF_LAST) begin
                    clk_count_d = '0;
                    bit_index_d = '0;
                    // High at the start-bit centre means the edge was a glitch.
                    state_d     = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    clk_count_d = clk_count_q + 14'd1;
                end
            end
            S_DATA: begin
                if (clk_count_q == BIT_LAST) begin
                    clk_count_d          = '0;
                    shift_d[bit_index_q] = rx_s_q;
                    if (bit_index_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end else begin
                    clk_count_d = clk_count_q + 14'd1;
                end
            end
            S_PARITY: begin
                if (clk_count_q == BIT_LAST) begin
                    clk_count_d  = '0;
                    parity_bit_d = rx_s_q;
                    state_d      = S_STOP;
                end else begin
                    clk_count_d = clk_count_q + 14'd1;
                end
            end
            S_STOP: begin
                // Leaving at the stop-bit centre leaves half a bit to catch the next start edge.
                if (clk_count_q == BIT_LAST) begin
                    clk_count_d = '0;
                    stop_bit_d  = rx_s_q;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    clk_count_d = clk_count_q + 14'd1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                clk_count_d = '0;
            end
        endcase

        rx_busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset parks the line high and clears everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= S_IDLE;
            clk_count_q  <= '0;
            bit_index_q  <= '0;
            shift_q      <= '0;
            parity_bit_q <= 1'b0;
            stop_bit_q   <= 1'b0;
            done_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
            led_cnt_q    <= '0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            rx_prev_q    <= rx_prev_d;
            state_q      <= state_d;
            clk_count_q  <= clk_count_d;
            bit_index_q  <= bit_index_d;
            shift_q      <= shift_d;
            parity_bit_q <= parity_bit_d;
            stop_bit_q   <= stop_bit_d;
            done_q       <= done_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            rx_busy_q    <= rx_busy_d;
            led_cnt_q    <= led_cnt_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = rx_busy_q;
    assign led        = (led_cnt_q != '0);

endmodule
